// File: rtl/vram_fill_if.sv
// AXI write-only channel bundle (AW/W/B) for the vram_fill master.
// Master drives address/data and BREADY; slave drives the ready/response side.
interface vram_fill_if #(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awuser;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wuser;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                buser;
  logic                bvalid;
  logic                bready;

  modport master (
    output awid,
    output awaddr,
    output awlen,
    output awsize,
    output awburst,
    output awlock,
    output awcache,
    output awprot,
    output awqos,
    output awuser,
    output awvalid,
    input  awready,
    output wdata,
    output wstrb,
    output wlast,
    output wuser,
    output wvalid,
    input  wready,
    input  bid,
    input  bresp,
    input  buser,
    input  bvalid,
    output bready
  );

  modport slave (
    input  awid,
    input  awaddr,
    input  awlen,
    input  awsize,
    input  awburst,
    input  awlock,
    input  awcache,
    input  awprot,
    input  awqos,
    input  awuser,
    input  awvalid,
    output awready,
    input  wdata,
    input  wstrb,
    input  wlast,
    input  wuser,
    input  wvalid,
    output wready,
    output bid,
    output bresp,
    output buser,
    output bvalid,
    input  bready
  );

endinterface

// File: rtl/vram_fill.sv
// Solid-colour rectangle fill: AXI write master issuing 32x64-bit bursts,
// one burst in flight, walking bursts across a line then lines by stride.
module vram_fill #(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 64
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        START,
  input  logic [28:0] DSTADDR,
  input  logic [5:0]  FILL_W,
  input  logic [10:0] FILL_H,
  input  logic [15:0] STRIDE,
  input  logic [23:0] COLOR,
  vram_fill_if.master m_axi,
  output logic        BUSY,
  output logic        DONE,
  output logic        BRESP_ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [28:0] cur_addr;
  logic [28:0] line_addr;
  logic [28:0] nxt_line;
  logic [5:0]  fill_w;
  logic [5:0]  burst_cnt;
  logic [10:0] fill_h;
  logic [10:0] line_cnt;
  logic [7:0]  stride_hi;
  logic [23:0] color;
  logic [4:0]  beat_cnt;
  logic        bresp_err;

  logic accept;
  logic zero_size;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic last_beat;
  logic burst_more;
  logic line_more;

  assign accept    = (state == S_IDLE) && START;
  assign zero_size = (FILL_W == 6'd0) || (FILL_H == 11'd0);
  assign aw_hs     = (state == S_AW) && m_axi.awready;
  assign w_hs      = (state == S_W) && m_axi.wready;
  assign b_hs      = (state == S_B) && m_axi.bvalid;
  assign last_beat = (beat_cnt == 5'd31);

  assign burst_more = (7'(burst_cnt) + 7'd1) < {1'b0, fill_w};
  assign line_more  = (12'(line_cnt) + 12'd1) < {1'b0, fill_h};

  // Stride low byte is dropped so every line start stays 256-byte aligned.
  assign nxt_line = line_addr + {13'd0, stride_hi, 8'd0};

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (START) begin
          state_nxt = zero_size ? S_DONE : S_AW;
        end
      end
      S_AW: begin
        if (m_axi.awready) begin
          state_nxt = S_W;
        end
      end
      S_W: begin
        if (m_axi.wready && last_beat) begin
          state_nxt = S_B;
        end
      end
      S_B: begin
        if (m_axi.bvalid) begin
          state_nxt = (burst_more || line_more) ? S_AW : S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      cur_addr  <= '0;
      line_addr <= '0;
      fill_w    <= '0;
      fill_h    <= '0;
      stride_hi <= '0;
      color     <= '0;
      burst_cnt <= '0;
      line_cnt  <= '0;
      beat_cnt  <= '0;
      bresp_err <= 1'b0;
    end else begin
      if (accept) begin
        cur_addr  <= {DSTADDR[28:8], 8'd0};
        line_addr <= {DSTADDR[28:8], 8'd0};
        fill_w    <= FILL_W;
        fill_h    <= FILL_H;
        stride_hi <= STRIDE[15:8];
        color     <= COLOR;
        burst_cnt <= '0;
        line_cnt  <= '0;
        beat_cnt  <= '0;
        bresp_err <= 1'b0;
      end
      if (aw_hs) begin
        beat_cnt <= '0;
      end
      if (w_hs) begin
        beat_cnt <= beat_cnt + 5'd1;
      end
      if (b_hs) begin
        if (m_axi.bresp != 2'b00) begin
          bresp_err <= 1'b1;
        end
        unique case (1'b1)
          burst_more: begin
            burst_cnt <= burst_cnt + 6'd1;
            cur_addr  <= cur_addr + 29'd256;
          end
          (!burst_more && line_more): begin
            burst_cnt <= '0;
            line_cnt  <= line_cnt + 11'd1;
            line_addr <= nxt_line;
            cur_addr  <= nxt_line;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Top bits pin the window to 0x20000000-0x3FFFFFFF.
  assign m_axi.awaddr  = C_M_AXI_ADDR_WIDTH'({3'b001, cur_addr[28:8], 8'h00});
  assign m_axi.awid    = C_M_AXI_THREAD_ID_WIDTH'(0);
  assign m_axi.awlen   = 8'h1F;
  assign m_axi.awsize  = 3'b011;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awqos   = 4'b0000;
  assign m_axi.awuser  = 1'b0;
  assign m_axi.awvalid = (state == S_AW);

  assign m_axi.wdata  = C_M_AXI_DATA_WIDTH'({8'h00, color, 8'h00, color});
  assign m_axi.wstrb  = '1;
  assign m_axi.wlast  = (state == S_W) && last_beat;
  assign m_axi.wuser  = 1'b0;
  assign m_axi.wvalid = (state == S_W);

  assign m_axi.bready = (state == S_B);

  assign BUSY      = (state == S_AW) || (state == S_W) || (state == S_B);
  assign DONE      = (state == S_DONE);
  assign BRESP_ERR = bresp_err;

  logic unused_ok;
  assign unused_ok = ^{DSTADDR[7:0], STRIDE[7:0], m_axi.bid, m_axi.buser};

endmodule

// File: tb/tb_vram_fill.sv
// Bench for vram_fill: AXI slave responder plus an AWADDR/WDATA scoreboard
// stepped once per cycle by the scenario tasks.
module tb_vram_fill;

  logic        ACLK;
  logic        ARESETN;
  logic        START;
  logic [28:0] DSTADDR;
  logic [5:0]  FILL_W;
  logic [10:0] FILL_H;
  logic [15:0] STRIDE;
  logic [23:0] COLOR;
  logic        BUSY;
  logic        DONE;
  logic        BRESP_ERR;

  vram_fill_if #(.ID_W(1), .ADDR_W(32), .DATA_W(64)) m ();

  vram_fill #(
    .C_M_AXI_THREAD_ID_WIDTH(1),
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(64)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .START(START),
    .DSTADDR(DSTADDR),
    .FILL_W(FILL_W),
    .FILL_H(FILL_H),
    .STRIDE(STRIDE),
    .COLOR(COLOR),
    .m_axi(m),
    .BUSY(BUSY),
    .DONE(DONE),
    .BRESP_ERR(BRESP_ERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_aw[$];
  logic [63:0] exp_wdata;

  int cyc = 0;
  int n_aw = 0;
  int n_whs = 0;
  int n_b = 0;
  int n_done = 0;
  int aw_stall = 0;
  int busy_cyc = 0;
  int w_beats = 0;
  int b_cyc = 0;
  int done_cyc = 0;
  bit aw_seen = 0;
  bit aw_prev_wait = 0;
  logic [31:0] aw_hold;

  int aw_wait = 0;
  bit w_tog = 0;
  int err_at = -1;
  int b_total = 0;
  int aw_cnt = 0;

  always @(posedge ACLK) begin
    if (m.bvalid && m.bready) b_total++;
    #1;
    if (!ARESETN) begin
      m.awready = 1'b0;
      m.wready  = 1'b0;
      m.bvalid  = 1'b0;
      m.bresp   = 2'b00;
      aw_cnt    = 0;
    end else begin
      if (m.awvalid) begin
        m.awready = (aw_cnt >= aw_wait);
        aw_cnt++;
      end else begin
        m.awready = 1'b0;
        aw_cnt = 0;
      end
      m.wready = w_tog ? !m.wready : 1'b1;
      m.bvalid = m.bready;
      m.bresp  = (b_total == err_at) ? 2'b10 : 2'b00;
    end
  end

  function automatic logic [31:0] exp_addr(logic [28:0] base,
                                           logic [15:0] s,
                                           int l, int b);
    logic [28:0] a;
    a = {base[28:8], 8'h00}
      + 29'(l) * {13'd0, s[15:8], 8'h00}
      + 29'(b) * 29'd256;
    return {3'b001, a[28:8], 8'h00};
  endfunction

  task automatic step();
    @(negedge ACLK);
    cyc++;
    if (!ARESETN) begin
      aw_seen = 0;
      w_beats = 0;
      aw_prev_wait = 0;
      return;
    end
    if (m.awvalid) begin
      if (aw_prev_wait) begin
        n_cmp++;
        if (m.awaddr !== aw_hold) begin
          n_err++;
          $display("FAIL aw_stable: awaddr %h, held %h", m.awaddr, aw_hold);
        end
      end
      aw_prev_wait = !m.awready;
      aw_hold = m.awaddr;
      if (!m.awready) aw_stall++;
    end else begin
      aw_prev_wait = 0;
    end
    if (m.awvalid && m.awready) begin
      n_aw++;
      n_cmp++;
      if (exp_aw.size() == 0) begin
        n_err++;
        $display("FAIL aw_unexpected: awaddr %h, none expected", m.awaddr);
      end else begin
        logic [31:0] e;
        e = exp_aw.pop_front();
        if (m.awaddr !== e) begin
          n_err++;
          $display("FAIL awaddr: got %h, expected %h", m.awaddr, e);
        end
      end
      n_cmp++;
      if (m.awlen !== 8'h1F) begin
        n_err++;
        $display("FAIL awlen: got %h, expected 1f", m.awlen);
      end
      aw_seen = 1;
      w_beats = 0;
    end
    if (m.wvalid) begin
      n_cmp++;
      if (!aw_seen) begin
        n_err++;
        $display("FAIL wvalid_early: wvalid 1 before AW handshake, expected 0");
      end
      n_cmp++;
      if (m.wdata !== exp_wdata) begin
        n_err++;
        $display("FAIL wdata: got %h, expected %h", m.wdata, exp_wdata);
      end
      if (m.wready) begin
        n_cmp++;
        if (m.wlast !== (w_beats == 31)) begin
          n_err++;
          $display("FAIL wlast: got %b at beat %0d", m.wlast, w_beats);
        end
        w_beats++;
        n_whs++;
      end
    end
    if (m.bvalid && m.bready) begin
      n_cmp++;
      if (w_beats !== 32) begin
        n_err++;
        $display("FAIL beats_per_burst: got %0d, expected 32", w_beats);
      end
      n_b++;
      b_cyc = cyc;
      aw_seen = 0;
    end
    if (DONE) begin
      n_done++;
      done_cyc = cyc;
    end
    if (BUSY) busy_cyc++;
  endtask

  task automatic start_fill(logic [28:0] a, logic [5:0] w, logic [10:0] h,
                            logic [15:0] s, logic [23:0] c);
    DSTADDR = a;
    FILL_W = w;
    FILL_H = h;
    STRIDE = s;
    COLOR = c;
    exp_wdata = {8'h00, c, 8'h00, c};
    if (w != 0 && h != 0) begin
      for (int l = 0; l < int'(h); l++)
        for (int b = 0; b < int'(w); b++)
          exp_aw.push_back(exp_addr(a, s, l, b));
    end
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic wait_done(int d0, int max, string name);
    for (int i = 0; i < max && n_done == d0; i++) step();
    n_cmp++;
    if (n_done == d0) begin
      n_err++;
      $display("FAIL %s_timeout: no DONE in %0d cycles", name, max);
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({m.awvalid, m.wvalid, m.wlast, m.bready, BUSY, DONE, BRESP_ERR}
        !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, expected 0",
        {m.awvalid, m.wvalid, m.wlast, m.bready, BUSY, DONE, BRESP_ERR});
    end
    ARESETN = 1'b1;
    step();
    n_cmp++;
    if ({m.awvalid, BUSY, DONE} !== 3'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b, expected 0",
        {m.awvalid, BUSY, DONE});
    end
  endtask

  task automatic test_basic();
    int d0, a0, w0, b0, s0, bz0;
    d0 = n_done; a0 = n_aw; w0 = n_whs; b0 = n_b;
    s0 = cyc; bz0 = busy_cyc;
    start_fill(29'h0100000, 6'd1, 11'd1, 16'h0000, 24'h123456);
    wait_done(d0, 200, "basic");
    n_cmp++;
    if (n_aw - a0 != 1 || n_b - b0 != 1) begin
      n_err++;
      $display("FAIL basic_bursts: aw %0d b %0d, expected 1 1",
        n_aw - a0, n_b - b0);
    end
    n_cmp++;
    if (n_whs - w0 != 32) begin
      n_err++;
      $display("FAIL basic_beats: got %0d, expected 32", n_whs - w0);
    end
    n_cmp++;
    if (done_cyc - b_cyc != 1) begin
      n_err++;
      $display("FAIL basic_done_lat: got %0d, expected 1", done_cyc - b_cyc);
    end
    n_cmp++;
    if (busy_cyc - bz0 != done_cyc - s0 - 1) begin
      n_err++;
      $display("FAIL basic_busy: busy %0d cycles, expected %0d",
        busy_cyc - bz0, done_cyc - s0 - 1);
    end
    step();
    n_cmp++;
    if ({DONE, BUSY} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_done_pulse: DONE,BUSY %b, expected 00", {DONE, BUSY});
    end
  endtask

  task automatic test_multi_line();
    int d0, a0, b0;
    d0 = n_done; a0 = n_aw; b0 = n_b;
    start_fill(29'h0000000, 6'd2, 11'd3, 16'h1000, 24'hA1B2C3);
    wait_done(d0, 600, "multi");
    step();
    n_cmp++;
    if (n_aw - a0 != 6 || n_b - b0 != 6) begin
      n_err++;
      $display("FAIL multi_bursts: aw %0d b %0d, expected 6 6",
        n_aw - a0, n_b - b0);
    end
    n_cmp++;
    if (n_done - d0 != 1 || exp_aw.size() != 0) begin
      n_err++;
      $display("FAIL multi_done: dones %0d left %0d, expected 1 0",
        n_done - d0, exp_aw.size());
    end
  endtask

  task automatic test_backpressure();
    int d0, w0, st0;
    d0 = n_done; w0 = n_whs; st0 = aw_stall;
    aw_wait = 5;
    w_tog = 1;
    start_fill(29'h0200000, 6'd1, 11'd1, 16'h0000, 24'h00FF7E);
    wait_done(d0, 400, "bp");
    aw_wait = 0;
    w_tog = 0;
    n_cmp++;
    if (aw_stall - st0 != 5) begin
      n_err++;
      $display("FAIL bp_aw_wait: got %0d, expected 5", aw_stall - st0);
    end
    n_cmp++;
    if (n_whs - w0 != 32) begin
      n_err++;
      $display("FAIL bp_beats: got %0d, expected 32", n_whs - w0);
    end
    step();
  endtask

  task automatic test_zero_busy();
    int d0, a0, s0;
    d0 = n_done; a0 = n_aw; s0 = cyc;
    start_fill(29'h0080000, 6'd3, 11'd0, 16'h0100, 24'h777777);
    wait_done(d0, 2, "zero");
    n_cmp++;
    if (done_cyc - s0 > 2 || n_aw != a0) begin
      n_err++;
      $display("FAIL zero_size: done at +%0d aw %0d, expected <=2 0",
        done_cyc - s0, n_aw - a0);
    end
    step();
    d0 = n_done; a0 = n_aw;
    start_fill(29'h0600000, 6'd2, 11'd1, 16'h0000, 24'h0F0F0F);
    for (int i = 0; i < 20; i++) step();
    DSTADDR = 29'h0700000;
    FILL_W = 6'd5;
    COLOR = 24'hDEAD00;
    START = 1'b1;
    step();
    START = 1'b0;
    wait_done(d0, 400, "busy_start");
    n_cmp++;
    if (n_aw - a0 != 2 || exp_aw.size() != 0) begin
      n_err++;
      $display("FAIL start_while_busy: aw %0d left %0d, expected 2 0",
        n_aw - a0, exp_aw.size());
    end
    step();
  endtask

  task automatic test_error_wrap();
    int d0, a0;
    d0 = n_done; a0 = n_aw;
    err_at = b_total;
    start_fill(29'h0400000, 6'd2, 11'd1, 16'h0000, 24'h102030);
    wait_done(d0, 400, "err");
    err_at = -1;
    n_cmp++;
    if (BRESP_ERR !== 1'b1 || n_aw - a0 != 2) begin
      n_err++;
      $display("FAIL err_sticky: BRESP_ERR %b aw %0d, expected 1 2",
        BRESP_ERR, n_aw - a0);
    end
    step();
    d0 = n_done;
    start_fill(29'h1FFFFF00, 6'd2, 11'd1, 16'h0000, 24'h405060);
    n_cmp++;
    if (BRESP_ERR !== 1'b0) begin
      n_err++;
      $display("FAIL err_clear: BRESP_ERR %b, expected 0", BRESP_ERR);
    end
    wait_done(d0, 400, "wrap");
    n_cmp++;
    if (exp_aw.size() != 0 || BRESP_ERR !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_done: left %0d err %b, expected 0 0",
        exp_aw.size(), BRESP_ERR);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int d0, a0, w0;
    start_fill(29'h0300000, 6'd1, 11'd1, 16'h0000, 24'h55AA55);
    for (int i = 0; i < 100 && w_beats < 10; i++) step();
    n_cmp++;
    if (w_beats != 10) begin
      n_err++;
      $display("FAIL mid_reach: beats %0d, expected 10", w_beats);
    end
    ARESETN = 1'b0;
    step();
    n_cmp++;
    if ({m.awvalid, m.wvalid, m.wlast, m.bready, BUSY, DONE, BRESP_ERR}
        !== 7'b0) begin
      n_err++;
      $display("FAIL mid_reset: outputs %b, expected 0",
        {m.awvalid, m.wvalid, m.wlast, m.bready, BUSY, DONE, BRESP_ERR});
    end
    exp_aw.delete();
    ARESETN = 1'b1;
    step();
    step();
    d0 = n_done; a0 = n_aw; w0 = n_whs;
    start_fill(29'h0500000, 6'd1, 11'd1, 16'h0000, 24'h0A0B0C);
    wait_done(d0, 200, "post_reset");
    n_cmp++;
    if (n_aw - a0 != 1 || n_whs - w0 != 32) begin
      n_err++;
      $display("FAIL post_reset: aw %0d beats %0d, expected 1 32",
        n_aw - a0, n_whs - w0);
    end
  endtask

  initial begin
    ARESETN = 1'b0;
    START = 1'b0;
    DSTADDR = '0;
    FILL_W = '0;
    FILL_H = '0;
    STRIDE = '0;
    COLOR = '0;
    exp_wdata = '0;
    m.bid = '0;
    m.buser = 1'b0;
    test_reset();
    test_basic();
    test_multi_line();
    test_backpressure();
    test_zero_busy();
    test_error_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
